// File: rtl/xor_frame_parity.sv
// rtl/xor_frame_parity.sv - streaming per-frame LRC, parity and word count with a one-deep result register
module xor_frame_parity #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             exp_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lrc,
    output logic             out_parity,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_acc_lrc;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic               r_acc_sat;

    logic [WIDTH-1:0]   r_out_lrc;
    logic               r_out_parity;
    logic               r_out_err;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_sat;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic [WIDTH-1:0]   w_lrc_next;
    logic               w_cnt_full;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sat_next;
    logic               w_parity_next;

    // One-deep output: a held result may be popped and replaced in the same cycle.
    assign w_in_ready    = (r_state == ST_ACC) || out_ready;
    assign w_accept      = in_valid && w_in_ready;
    assign w_load        = w_accept && in_last;

    assign w_lrc_next    = r_acc_lrc ^ in_data;
    assign w_cnt_full    = &r_acc_cnt;
    assign w_cnt_next    = w_cnt_full ? r_acc_cnt : r_acc_cnt + CNT_W'(1);
    assign w_sat_next    = r_acc_sat | w_cnt_full;
    assign w_parity_next = (^w_lrc_next) ^ ODD;

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = ST_HOLD;
        end else if ((r_state == ST_HOLD) && out_ready) begin
            w_state_next = ST_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulators clear on the last beat so the next frame starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_lrc <= '0;
            r_acc_cnt <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc_lrc <= '0;
                r_acc_cnt <= '0;
                r_acc_sat <= 1'b0;
            end else begin
                r_acc_lrc <= w_lrc_next;
                r_acc_cnt <= w_cnt_next;
                r_acc_sat <= w_sat_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_lrc    <= '0;
            r_out_parity <= ODD;
            r_out_err    <= 1'b0;
            r_out_count  <= '0;
            r_out_sat    <= 1'b0;
        end else if (w_load) begin
            r_out_lrc    <= w_lrc_next;
            r_out_parity <= w_parity_next;
            r_out_err    <= w_parity_next ^ exp_parity;
            r_out_count  <= w_cnt_next;
            r_out_sat    <= w_sat_next;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state == ST_HOLD);
    assign out_lrc    = r_out_lrc;
    assign out_parity = r_out_parity;
    assign out_err    = r_out_err;
    assign out_count  = r_out_count;
    assign out_sat    = r_out_sat;

endmodule

// File: doc/xor_frame_parity.md
# xor_frame_parity

Parametrised streaming XOR unit. Accepts a stream of WIDTH-bit words grouped into frames. For each frame it accumulates a column-wise XOR (LRC, longitudinal redundancy check), an overall even/odd parity bit and a word count. It presents the frame result on a registered output with a valid/ready handshake. It is the sequential, multi-bit successor to the single-gate XOR cell and sits between a data source and any framing/checking logic that needs per-frame parity or LRC.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- ODD, 0, 0 = even parity, 1 = odd parity on out_parity
- CNT_W, 4, width of frame word counter (saturating)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  unit can accept a word this cycle
- in_data  in  WIDTH  input word
- in_last  in  1  marks final word of frame (qualified by in_valid)
- exp_parity  in  1  expected frame parity, sampled with the last word
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- out_lrc  out  WIDTH  XOR of all words in frame
- out_parity  out  1  XOR of all bits in frame, inverted when ODD=1
- out_err  out  1  out_parity != exp_parity
- out_count  out  CNT_W  words in frame, saturating at 2^CNT_W-1
- out_sat  out  1  frame word count exceeded 2^CNT_W-1

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (one-deep output, pop-and-push allowed in same cycle).
- States:
  - ACC: accumulate. Running registers acc_lrc (WIDTH), acc_cnt (CNT_W), acc_sat. Reset state.
  - HOLD: result held, out_valid=1.
- Non-last beat in ACC:
  - acc_lrc <= acc_lrc ^ in_data.
  - acc_cnt increments; it saturates at all-ones, and an increment attempted at all-ones sets acc_sat.
- Last beat:
  - Result registers load out_lrc = acc_lrc ^ in_data, out_count = acc_cnt+1 (saturating, with out_sat updated the same way).
  - out_parity = (^(acc_lrc ^ in_data)) ^ ODD. out_err = out_parity ^ exp_parity.
  - Accumulators clear to 0 in the same edge. The state becomes HOLD.
- HOLD with out_ready=1:
  - out_valid drops next cycle unless a new last beat is accepted in the same cycle. In that case the new result loads and out_valid stays 1.
  - Non-last beats accepted during that pop cycle accumulate into the cleared accumulators normally.
- HOLD with out_ready=0: in_ready=0, the output is stable, and no accumulation occurs.
- A single-word frame (in_last on the first beat) is legal and gives out_count=1.
- Frame parity equals the XOR-reduce of out_lrc (^ODD).
- No transformation is applied to in_data; the LRC is a pure bitwise XOR.

## Timing
- Reset (async assert, sync release to clk):
  - out_valid=0, out_lrc=0, out_parity=ODD, out_err=0, out_count=0, out_sat=0.
  - Accumulators are 0 and the state is ACC. in_ready=1 from the first cycle after reset release.
- Latency: the result is visible the cycle after the edge that accepts the last beat. Throughput is one word per cycle, including back-to-back single-word frames when out_ready=1.
- Reset mid-frame discards the partial accumulation and any held result immediately, with no output pulse.
- out_* change only on the edge that loads a new result. They are stable while out_valid && !out_ready.
- exp_parity and in_last are ignored when in_valid=0.

## Test plan
- WIDTH=8, ODD=0: frame 0x0F, 0xF0, 0x01 (last), exp_parity=1 -> next cycle out_valid=1, out_lrc=0xFE, out_parity=1, out_err=0, out_count=3.
- Same frame with ODD=1, exp_parity=1 -> out_parity=0, out_err=1.
- Backpressure: out_ready=0 after a result -> in_ready=0, and a 0xAA held on in_data is not absorbed. Raise out_ready together with a single-word frame 0x55 (last) -> next cycle out_lrc=0x55, out_count=1, out_valid stays 1.
- CNT_W=4: 17-word frame of 0x01 -> out_count=15, out_sat=1, out_lrc=0x01, out_parity=1.
- Assert rst_n=0 after 2 words of a frame (0x12, 0x34), release, then send 0x80 (last) -> out_lrc=0x80, out_count=1; outputs read reset values during reset.
- Random streams, 1000 frames with random valid/ready -> the scoreboard matches the LRC, parity and count, and no beats are lost or duplicated.
